// File: rtl/secure_boot_hash_seq.sv
// Secure-boot sequencer: packs a 32-bit boot image into 512-bit SHA blocks, drives the
// SHA init/next handshake and compares the final digest. SECBOOT_TIMEOUT_EN adds a SHA watchdog.
module secure_boot_hash_seq #(
    parameter int unsigned MAX_BLOCKS     = 1024,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [255:0]     golden_digest,
    input  logic [31:0]      word_in,
    input  logic             word_valid,
    input  logic             word_last,
    output logic             word_ready,
    output logic [511:0]     sha_block,
    output logic             sha_init,
    output logic             sha_next,
    output logic             sha_sel,
    input  logic             sha_ready,
    input  logic [255:0]     sha_digest,
    input  logic             sha_digest_valid,
    output logic             busy,
    output logic             done,
    output logic             boot_ok,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] block_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_CHECK   = 3'd5,
        ST_PASS    = 3'd6,
        ST_FAIL    = 3'd7
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ALIGN    = 3'd1;
    localparam logic [2:0] ERR_DIGEST   = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    if ((TIMEOUT_CYCLES == 0) || (MAX_BLOCKS >= (64'd1 << CNT_W))) begin : g_cfg_bad
        $error("secure_boot_hash_seq: CNT_W too narrow for MAX_BLOCKS or zero TIMEOUT_CYCLES");
    end

    // Word index w lands in bits [511-32w -: 32] so the first word occupies the MSBs.
    function automatic logic [8:0] lane_msb(input logic [3:0] idx);
        return 9'd511 - {idx, 5'd0};
    endfunction

    state_e           state_q, state_d;
    logic [511:0]     block_q, block_d;
    logic [3:0]       word_idx_q, word_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       err_q, err_d;
    logic             last_seen_q, last_seen_d;
    logic             init_q, init_d;
    logic             next_q, next_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             boot_ok_q, boot_ok_d;
    logic [8:0]       lane_s;

`ifdef SECBOOT_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_active_s;
    logic            wd_expired_s;

    assign wd_active_s  = (state_q == ST_ISSUE) || (state_q == ST_WAIT_LO) ||
                          (state_q == ST_WAIT_HI) || (state_q == ST_CHECK);
    assign wd_expired_s = wd_active_s && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    assign lane_s      = lane_msb(word_idx_q);
    assign word_ready  = (state_q == ST_FILL);
    assign sha_block   = block_q;
    assign sha_init    = init_q;
    assign sha_next    = next_q;
    assign sha_sel     = 1'b0;
    assign busy        = busy_q;
    assign done        = done_q;
    assign boot_ok     = boot_ok_q;
    assign err_code    = err_q;
    assign block_count = count_q;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        block_d     = block_q;
        word_idx_d  = word_idx_q;
        count_d     = count_q;
        err_d       = err_q;
        last_seen_d = last_seen_q;
        init_d      = 1'b0;
        next_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d     = ST_FILL;
                    word_idx_d  = 4'd0;
                    count_d     = '0;
                    err_d       = ERR_NONE;
                    last_seen_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FILL: begin
                if (word_valid) begin
                    block_d[lane_s -: 32] = word_in;
                    if (word_idx_q == 4'd15) begin
                        state_d     = ST_ISSUE;
                        last_seen_d = word_last;
                        word_idx_d  = 4'd0;
                    end else if (word_last) begin
                        state_d    = ST_FAIL;
                        err_d      = ERR_ALIGN;
                        word_idx_d = word_idx_q + 4'd1;
                    end else begin
                        word_idx_d = word_idx_q + 4'd1;
                    end
                end else begin
                    word_idx_d = word_idx_q;
                end
            end
            ST_ISSUE: begin
                if (count_q == CNT_W'(MAX_BLOCKS)) begin
                    state_d = ST_FAIL;
                    err_d   = ERR_OVERFLOW;
                end else if (sha_ready) begin
                    init_d  = (count_q == '0);
                    next_d  = (count_q != '0);
                    count_d = count_q + CNT_W'(1'b1);
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_LO: begin
                if (!sha_ready) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (sha_ready) begin
                    state_d = last_seen_q ? ST_CHECK : ST_FILL;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_CHECK: begin
                if (sha_digest_valid) begin
                    if (sha_digest == golden_digest) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_FAIL;
                        err_d   = ERR_DIGEST;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SECBOOT_TIMEOUT_EN
        // The watchdog only fires when no regular transition is taken this cycle.
        if (wd_expired_s && (state_d == state_q)) begin
            state_d = ST_FAIL;
            err_d   = ERR_TIMEOUT;
        end else begin
            state_d = state_d;
        end
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (wd_active_s) begin
            wd_d = wd_q + WD_W'(1'b1);
        end else begin
            wd_d = '0;
        end
`endif

        done_d    = (state_d == ST_PASS) || (state_d == ST_FAIL);
        boot_ok_d = (state_d == ST_PASS);
        busy_d    = !((state_d == ST_IDLE) || (state_d == ST_PASS) || (state_d == ST_FAIL));
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            block_q     <= '0;
            word_idx_q  <= 4'd0;
            count_q     <= '0;
            err_q       <= ERR_NONE;
            last_seen_q <= 1'b0;
            init_q      <= 1'b0;
            next_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            boot_ok_q   <= 1'b0;
`ifdef SECBOOT_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            word_idx_q  <= word_idx_d;
            count_q     <= count_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
            init_q      <= init_d;
            next_q      <= next_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            boot_ok_q   <= boot_ok_d;
`ifdef SECBOOT_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

endmodule

// File: doc/secure_boot_hash_seq.md
Name: secure_boot_hash_seq

Overview:
- Boot-time sequencer directly upstream of the SHA-256 engine in the minimum security module.
- Accepts a pre-padded boot image as a 32-bit word stream and packs it into 512-bit blocks.
- Drives the SHA block/init/next handshake for each block, then compares the final digest against a golden digest.
- Reports pass/fail to boot control; boot_ok gates release of the boot GPIOs.

Parameters:
- MAX_BLOCKS, 1024: maximum 512-bit blocks per image; exceeding it fails.
- CNT_W, 16: width of block_count; must hold MAX_BLOCKS.
- TIMEOUT_CYCLES, 4096: SHA response watchdog limit; used only with SECBOOT_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- nreset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new image check.
- golden_digest  input  256  expected digest; sampled in CHECK.
- word_in  input  32  image word.
- word_valid  input  1  word_in valid.
- word_last  input  1  qualifies the final word of the image.
- word_ready  output  1  sequencer accepts a word this cycle.
- sha_block  output  512  block to the SHA core.
- sha_init  output  1  one-cycle pulse; first block.
- sha_next  output  1  one-cycle pulse; subsequent blocks.
- sha_sel  output  1  SHA mode select; tied 0 (hash mode).
- sha_ready  input  1  SHA core idle.
- sha_digest  input  256  SHA result.
- sha_digest_valid  input  1  sha_digest valid.
- busy  output  1  state not in IDLE/PASS/FAIL.
- done  output  1  in PASS or FAIL.
- boot_ok  output  1  high only in PASS.
- err_code  output  3  0 none, 1 misaligned last, 2 digest mismatch, 3 block overflow, 4 timeout.
- block_count  output  CNT_W  blocks issued for the current image.

Behaviour:
- Reset (nreset low, async):
  - State IDLE.
  - All outputs 0: sha_block, word_idx, block_count, err_code, boot_ok, done, word_ready, sha_init, sha_next.
  - last_seen cleared.
- IDLE/PASS/FAIL:
  - start moves to FILL.
  - Clears word_idx, block_count, err_code, boot_ok, last_seen.
  - start in any other state is ignored.
- FILL:
  - word_ready = 1 (combinational on state).
  - On word_valid & word_ready, word_in is written to sha_block[511-32*word_idx -: 32]. The first word occupies the MSBs.
  - word_idx increments after each accepted word.
  - word_last on an accepted word with word_idx != 15 → FAIL, err 1.
  - Word accepted at word_idx 15 → ISSUE; last_seen = word_last; word_idx wraps to 0.
  - word_ready = 0 in every other state.
- ISSUE:
  - If block_count == MAX_BLOCKS → FAIL, err 3.
  - Otherwise wait for sha_ready = 1.
  - Then pulse sha_init (block_count == 0) or sha_next (otherwise) for exactly one cycle, increment block_count, and go to WAIT_LO.
- WAIT_LO: wait for sha_ready = 0, then WAIT_HI.
- WAIT_HI:
  - Wait for sha_ready = 1.
  - If last_seen → CHECK; else → FILL.
- CHECK:
  - Wait for sha_digest_valid.
  - sha_digest == golden_digest → PASS; otherwise → FAIL, err 2.
- PASS: done = 1, boot_ok = 1. FAIL: done = 1, boot_ok = 0. Both hold until start or reset.
- sha_block is stable from ISSUE through WAIT_HI. It is only modified by accepted words in FILL.
- Reset mid-operation: immediate return to IDLE, boot_ok = 0. A SHA operation in flight is ignored; the next image issues sha_init again.
- err_code is written once on entry to FAIL and never overwritten within the same image.
- Latency: at least 3 cycles from the ISSUE pulse to FILL re-entry. CHECK → PASS/FAIL is 1 cycle after sha_digest_valid.

Optional Feature:
- SECBOOT_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to ISSUE, WAIT_LO, WAIT_HI and CHECK, and increments every cycle spent in those states.
  - Reaching TIMEOUT_CYCLES → FAIL, err 4.
- Undefined: no counter is built; the sequencer waits indefinitely and err 4 is never produced.

Test Plan:
- Single-block image: "abc" padded (words 0x61626380, 0x0 ×14, 0x00000018 with last); golden = ba7816bf…f20015ad.
  → one sha_init pulse, no sha_next, block_count = 1, PASS, boot_ok = 1, err_code = 0.
- Two-block image (32 words, last on word 32) with matching golden.
  → sha_init then exactly one sha_next, block_count = 2, PASS.
- Same "abc" image with golden bit 0 flipped → FAIL, err_code = 2, boot_ok = 0, done = 1.
- word_last asserted on word 7 → FAIL, err_code = 1; no sha_init issued.
- SECBOOT_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and sha_ready held 1 after init → FAIL, err_code = 4 after 16 cycles in WAIT_LO.
- nreset pulsed during WAIT_HI of block 2 → all outputs 0 asynchronously; a fresh start re-runs the "abc" image to PASS with sha_init.
